write_buffer: RTL and testbench

- Word-granular FIFO between the write-through direct-mapped data cache and data memory.
- Every store accepted by the cache is queued here and drained to memory one word per accepted handshake, so the pipeline does not wait on memory write latency.
- Provides combinational store-to-load forwarding, so a load that misses in the cache still sees the newest buffered store to its word.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_fwd_match.sv | 44 ++++
 rtl/write_buffer.sv | 131 +++++++++++++
 tb/tb_write_buffer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and helpers for the write buffer that sits between the
// write-through data cache and data memory.
//   WB_ADDR_WIDTH / WB_DATA_WIDTH : widths baked into the entry struct
//   WB_DEPTH                      : default number of buffer entries
//   wb_entry_t                    : one buffered store {valid, word_addr, data}
//   wbPtrInc                      : ring pointer increment modulo depth
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_DEPTH      = 4;

  // The byte offset is dropped on entry, so only the word address is kept.
  typedef struct packed {
    logic                     valid;
    logic [WB_ADDR_WIDTH-3:0] word_addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  // Advance a ring pointer by one, wrapping at the buffer depth.
  function automatic int wbPtrInc(input int ptr, input int depth);
    return (ptr + 1) % depth;
  endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// ---------------------------------------------------------------------------
// wb_fwd_match
// Store-to-load forwarding lookup for the write buffer. Compares a load word
// address against every valid entry and returns the youngest match.
//   entries_i    : full entry array as currently stored
//   tail_i       : next write slot; tail_i-1 is the youngest entry
//   lkWordAddr_i : load word address (byte offset already removed)
//   hit_o        : some valid entry matches
//   data_o       : data of the youngest matching entry, 0 when no hit
// ---------------------------------------------------------------------------
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t                entries_i [DEPTH],
  input  logic [PTR_W-1:0]         tail_i,
  input  logic [WB_ADDR_WIDTH-3:0] lkWordAddr_i,
  output logic                     hit_o,
  output logic [WB_DATA_WIDTH-1:0] data_o
);

  logic [PTR_W-1:0] slotIdx;

  // Walk the ring from the oldest possible slot towards tail-1. Each later
  // match overrides an earlier one, so the youngest matching entry is what
  // survives at the end of the loop. Invalid slots never match, which keeps
  // popped or never-written slots out of the result.
  always_comb begin
    hit_o   = 1'b0;
    data_o  = '0;
    slotIdx = '0;
    for (int age = DEPTH - 1; age >= 0; age--) begin
      slotIdx = tail_i - PTR_W'(age + 1);
      if (entries_i[slotIdx].valid &&
          (entries_i[slotIdx].word_addr == lkWordAddr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[slotIdx].data;
      end
    end
  end

endmodule

// File: rtl/write_buffer.sv
// ---------------------------------------------------------------------------
// write_buffer
// Word-granular store FIFO between the write-through cache and data memory,
// with combinational store-to-load forwarding.
//   clk, rst              : clock, synchronous active-high reset
//   wr_valid/wr_ready     : store handshake from the cache side
//   wr_addr, wr_data      : store byte address (offset ignored) and word
//   mem_valid/mem_ready   : drain handshake towards memory (head entry)
//   mem_addr, mem_data    : head entry word address (offset 0) and data
//   lk_addr               : load address checked for forwarding
//   lk_hit, lk_data       : youngest buffered match, data 0 when no hit
//   count, empty, full    : occupancy status
// The entry struct widths come from wb_pkg, so ADDR_WIDTH/DATA_WIDTH must
// stay equal to WB_ADDR_WIDTH/WB_DATA_WIDTH.
// ---------------------------------------------------------------------------
module write_buffer
  import wb_pkg::*;
#(
  parameter  int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter  int DATA_WIDTH = WB_DATA_WIDTH,
  parameter  int DEPTH      = WB_DEPTH,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [ADDR_WIDTH-1:0] lk_addr,
  output logic                  lk_hit,
  output logic [DATA_WIDTH-1:0] lk_data,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full
);

  wb_entry_t        entries_q [DEPTH];
  wb_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0] headPtr_q, headPtr_d;
  logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
  logic [CNT_W-1:0] count_q,   count_d;

  logic push;
  logic pop;
  logic unusedAddrBits;

  // Status comes purely from the occupancy counter; the pointers wrap
  // silently and are equal both when empty and when full.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign wr_ready  = !full;
  assign mem_valid = !empty;

  assign push = wr_valid && wr_ready;
  assign pop  = mem_valid && mem_ready;

  // Memory sees the registered head slot directly, so the presented word
  // cannot change while memory stalls.
  assign mem_addr = {entries_q[headPtr_q].word_addr, 2'b00};
  assign mem_data = entries_q[headPtr_q].data;

  // Byte offsets carry no information for word-granular stores and loads.
  assign unusedAddrBits = ^{wr_addr[1:0], lk_addr[1:0]};

  // Next-state logic for the FIFO. A push lands at tail and a pop clears the
  // head valid bit. Both can target the same slot only when the buffer is
  // empty or full, and in those cases one of them is blocked, so the two
  // updates never collide.
  always_comb begin
    entries_d = entries_q;
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    count_d   = count_q;

    if (push) begin
      entries_d[tailPtr_q].valid     = 1'b1;
      entries_d[tailPtr_q].word_addr = wr_addr[ADDR_WIDTH-1:2];
      entries_d[tailPtr_q].data      = wr_data;
      tailPtr_d = PTR_W'(wbPtrInc(32'(tailPtr_q), DEPTH));
    end

    if (pop) begin
      entries_d[headPtr_q].valid = 1'b0;
      headPtr_d = PTR_W'(wbPtrInc(32'(headPtr_q), DEPTH));
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers. Reset discards every pending store, including any
  // handshake that happens to be in flight in the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
    end
  end

  // Forwarding looks only at stored entries, so a store being pushed this
  // cycle is not visible yet while a head being popped still is.
  wb_fwd_match #(
    .DEPTH (DEPTH)
  ) uFwdMatch (
    .entries_i    (entries_q),
    .tail_i       (tailPtr_q),
    .lkWordAddr_i (lk_addr[ADDR_WIDTH-1:2]),
    .hit_o        (lk_hit),
    .data_o       (lk_data)
  );

endmodule

// File: tb/tb_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_write_buffer
// Self-checking bench for write_buffer. Accepted stores are predicted into a
// scoreboard queue and compared in order against every memory handshake.
// ---------------------------------------------------------------------------
module tb_write_buffer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] lk_addr;
  logic          lk_hit;
  logic [DW-1:0] lk_data;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  logic [63:0] sbQ [$];
  int          checks    = 0;
  int          failures  = 0;
  int          memWrites = 0;
  bit          started   = 1'b0;
  int          writesBefore;

  write_buffer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .lk_addr   (lk_addr),
    .lk_hit    (lk_hit),
    .lk_data   (lk_data),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of store/drain inputs; called just after a posedge
  task automatic applyStimulus(input logic v, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic mr);
    wr_valid  = v;
    wr_addr   = a;
    wr_data   = d;
    mem_ready = mr;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic toDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic waitEmpty(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (empty) break;
    end
    checkOutput("drain_done", 64'(empty), 64'(1));
  endtask

  // Scoreboard monitor: on each falling edge, predict what the coming
  // posedge does from the bench's own occupancy model, check status outputs,
  // and compare any memory handshake against the oldest predicted store.
  always @(negedge clk) begin
    logic [63:0] expTxn;
    bit          acceptExp;
    if (rst) begin
      sbQ.delete();
    end else if (started) begin
      acceptExp = (sbQ.size() < DEPTH);
      checkOutput("count",     64'(count),     64'(sbQ.size()));
      checkOutput("mem_valid", 64'(mem_valid), 64'(sbQ.size() != 0));
      checkOutput("wr_ready",  64'(wr_ready),  64'(acceptExp));
      checkOutput("empty",     64'(empty),     64'(sbQ.size() == 0));
      checkOutput("full",      64'(full),      64'(sbQ.size() == DEPTH));
      if (mem_valid && mem_ready) begin
        memWrites++;
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          expTxn = sbQ.pop_front();
          checkOutput("mem_addr", 64'(mem_addr), 64'(expTxn[63:32]));
          checkOutput("mem_data", 64'(mem_data), 64'(expTxn[31:0]));
        end
      end
      if (wr_valid && acceptExp) begin
        sbQ.push_back({wr_addr & 32'hFFFF_FFFC, wr_data});
      end
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    mem_ready = 1'b0;
    lk_addr   = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    started = 1'b1;

    $display("[TB] reset and idle");
    @(negedge clk);
    checkOutput("rst_wr_ready",  64'(wr_ready),  64'(1));
    checkOutput("rst_mem_valid", 64'(mem_valid), 64'(0));
    checkOutput("rst_count",     64'(count),     64'(0));
    checkOutput("rst_lk_hit0",   64'(lk_hit),    64'(0));
    checkOutput("rst_lk_data0",  64'(lk_data),   64'(0));
    lk_addr = 32'h0000_0100;
    #1;
    checkOutput("rst_lk_hit1",   64'(lk_hit),    64'(0));
    toDrive();

    $display("[TB] single store with memory stall");
    applyStimulus(1'b1, 32'h0000_0100, 32'hAAAA_0001, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("stall_mem_valid", 64'(mem_valid), 64'(1));
      checkOutput("stall_mem_addr",  64'(mem_addr),  64'h100);
      checkOutput("stall_mem_data",  64'(mem_data),  64'hAAAA_0001);
      checkOutput("stall_count",     64'(count),     64'(1));
      toDrive();
    end
    mem_ready = 1'b1;
    waitEmpty(8);
    toDrive();
    mem_ready = 1'b0;

    $display("[TB] fill to full, reject fifth store, drain in order");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h10 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0);
    end
    @(negedge clk);
    checkOutput("full_flag",     64'(full),     64'(1));
    checkOutput("full_wr_ready", 64'(wr_ready), 64'(0));
    checkOutput("full_count",    64'(count),    64'(4));
    toDrive();
    writesBefore = memWrites;
    applyStimulus(1'b1, 32'h20, 32'hDEAD_0005, 1'b0);
    @(negedge clk);
    checkOutput("fifth_reject", 64'(count), 64'(4));
    toDrive();
    mem_ready = 1'b1;
    waitEmpty(10);
    checkOutput("drain_four", 64'(memWrites - writesBefore), 64'(4));
    toDrive();
    mem_ready = 1'b0;

    $display("[TB] forwarding");
    applyStimulus(1'b1, 32'h40, 32'h1, 1'b0);
    applyStimulus(1'b1, 32'h40, 32'h2, 1'b0);
    lk_addr = 32'h42;
    @(negedge clk);
    checkOutput("fwd_young_hit",  64'(lk_hit),  64'(1));
    checkOutput("fwd_young_data", 64'(lk_data), 64'h2);
    lk_addr = 32'h44;
    #1;
    checkOutput("fwd_miss_hit",  64'(lk_hit),  64'(0));
    checkOutput("fwd_miss_data", 64'(lk_data), 64'(0));
    toDrive();
    wr_valid = 1'b1;
    wr_addr  = 32'h48;
    wr_data  = 32'h3;
    lk_addr  = 32'h48;
    @(negedge clk);
    checkOutput("fwd_same_cycle", 64'(lk_hit), 64'(0));
    toDrive();
    wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("fwd_next_hit",  64'(lk_hit),  64'(1));
    checkOutput("fwd_next_data", 64'(lk_data), 64'h3);
    toDrive();
    lk_addr   = 32'h40;
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("fwd_pop1_hit",  64'(lk_hit),  64'(1));
    checkOutput("fwd_pop1_data", 64'(lk_data), 64'h2);
    toDrive();
    @(negedge clk);
    checkOutput("fwd_pop2_hit",  64'(lk_hit),  64'(1));
    checkOutput("fwd_pop2_data", 64'(lk_data), 64'h2);
    toDrive();
    @(negedge clk);
    checkOutput("fwd_after_pop", 64'(lk_hit), 64'(0));
    waitEmpty(4);
    toDrive();
    mem_ready = 1'b0;

    $display("[TB] simultaneous push and pop with pointer wrap");
    writesBefore = memWrites;
    applyStimulus(1'b1, 32'h303, 32'h5000, 1'b0);
    applyStimulus(1'b1, 32'h307, 32'h5001, 1'b0);
    for (int i = 0; i < 12; i++) begin
      wr_valid  = 1'b1;
      wr_addr   = 32'h303 + 32'(4 * (i + 2));
      wr_data   = 32'h5002 + 32'(i);
      mem_ready = 1'b1;
      @(negedge clk);
      checkOutput("pp_count", 64'(count), 64'(2));
      toDrive();
    end
    wr_valid = 1'b0;
    waitEmpty(6);
    checkOutput("pp_writes", 64'(memWrites - writesBefore), 64'(14));
    toDrive();
    mem_ready = 1'b0;

    $display("[TB] forwarding across the ring wrap");
    applyStimulus(1'b1, 32'h80, 32'h5, 1'b0);
    applyStimulus(1'b1, 32'h80, 32'h6, 1'b0);
    applyStimulus(1'b1, 32'h80, 32'h7, 1'b0);
    lk_addr = 32'h80;
    @(negedge clk);
    checkOutput("fwd_wrap_hit",  64'(lk_hit),  64'(1));
    checkOutput("fwd_wrap_data", 64'(lk_data), 64'h7);
    checkOutput("wrap_count",    64'(count),   64'(3));
    toDrive();

    $display("[TB] reset with pending stores");
    writesBefore = memWrites;
    rst       = 1'b1;
    mem_ready = 1'b1;
    toDrive();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_count",     64'(count),     64'(0));
    checkOutput("mid_rst_mem_valid", 64'(mem_valid), 64'(0));
    checkOutput("mid_rst_lk_hit",    64'(lk_hit),    64'(0));
    repeat (5) @(negedge clk);
    checkOutput("no_write_after_rst", 64'(memWrites), 64'(writesBefore));
    mem_ready = 1'b0;

    $display("[TB] End of test - %0d assertions evaluated, %0d failures",
             checks, failures);
    $finish;
  end

endmodule
